// File: rtl/rv_pkg.sv
// Shared RV32I pipeline types and helpers used by the execute stage.
// EX_SERIAL_SHIFT_EN selects the multi-cycle shifter in ex_stage/ex_alu.
package rv_pkg;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_PASSB = 4'd10
    } alu_op_e;

    typedef enum logic [1:0] {
        RD_SRC_ALU  = 2'b00,
        RD_SRC_LOAD = 2'b01,
        RD_SRC_LINK = 2'b10
    } rd_src_e;

    localparam logic [2:0] BR_EQ  = 3'b000;
    localparam logic [2:0] BR_NE  = 3'b001;
    localparam logic [2:0] BR_LT  = 3'b100;
    localparam logic [2:0] BR_GE  = 3'b101;
    localparam logic [2:0] BR_LTU = 3'b110;
    localparam logic [2:0] BR_GEU = 3'b111;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ex_state_e;

    // EX's own result wins over writeback; loads in EX have no data yet, x0 never forwards.
    function automatic logic [31:0] fwd_operand(
        input logic [4:0]  rs,
        input logic [31:0] rf_data,
        input logic [4:0]  ex_rd,
        input logic        ex_wr_en,
        input logic [1:0]  ex_rd_src,
        input logic [31:0] ex_data,
        input logic [4:0]  wb_rd,
        input logic        wb_wr_en,
        input logic [31:0] wb_data
    );
        logic [31:0] val;
        val = rf_data;
        if (rs != 5'd0) begin
            if (ex_wr_en && (ex_rd_src != RD_SRC_LOAD) && (ex_rd == rs)) begin
                val = ex_data;
            end else if (wb_wr_en && (wb_rd == rs)) begin
                val = wb_data;
            end
        end
        return val;
    endfunction

    function automatic logic [31:0] shift_one(input logic [31:0] val, input logic [3:0] op);
        logic [31:0] res;
        case (op)
            ALU_SLL: res = {val[30:0], 1'b0};
            ALU_SRA: res = {val[31], val[31:1]};
            default: res = {1'b0, val[31:1]};
        endcase
        return res;
    endfunction

endpackage

// File: rtl/ex_alu.sv
// Combinational RV32I ALU. With EX_SERIAL_SHIFT_EN defined the barrel shifter
// is dropped and shift ops pass operand A through (the shamt==0 case).
module ex_alu
    import rv_pkg::*;
(
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic [3:0]  alu_op,
    output logic [31:0] result
);

`ifndef EX_SERIAL_SHIFT_EN
    logic [4:0] shamt;
    assign shamt = op_b[4:0];
`endif

    always_comb begin
        result = '0;
        case (alu_op_e'(alu_op))
            ALU_ADD:   result = op_a + op_b;
            ALU_SUB:   result = op_a - op_b;
            ALU_SLT:   result = {31'd0, $signed(op_a) < $signed(op_b)};
            ALU_SLTU:  result = {31'd0, op_a < op_b};
            ALU_XOR:   result = op_a ^ op_b;
            ALU_OR:    result = op_a | op_b;
            ALU_AND:   result = op_a & op_b;
            ALU_PASSB: result = op_b;
`ifdef EX_SERIAL_SHIFT_EN
            ALU_SLL, ALU_SRL, ALU_SRA: result = op_a;
`else
            ALU_SLL:   result = op_a << shamt;
            ALU_SRL:   result = op_a >> shamt;
            ALU_SRA:   result = 32'($signed(op_a) >>> shamt);
`endif
            default:   result = '0;
        endcase
    end

endmodule

// File: rtl/ex_stage.sv
// RV32I execute stage: operand forwarding, ALU, branch/jump redirect, EX/MEM register.
// Define EX_SERIAL_SHIFT_EN to replace the barrel shifter with a 1-bit/cycle shifter.
module ex_stage
    import rv_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        ID_valid_i,
    input  logic [31:0] ID_pc_i,
    input  logic [31:0] ID_rs1_data_i,
    input  logic [31:0] ID_rs2_data_i,
    input  logic [4:0]  ID_rs1_i,
    input  logic [4:0]  ID_rs2_i,
    input  logic [4:0]  ID_rd_i,
    input  logic [31:0] ID_imm_i,
    input  logic [3:0]  ID_alu_op_i,
    input  logic        ID_alu_src_a_i,
    input  logic        ID_alu_src_b_i,
    input  logic        ID_branch_i,
    input  logic        ID_jump_i,
    input  logic        ID_jalr_i,
    input  logic [2:0]  ID_br_funct3_i,
    input  logic        ID_rd_wr_en_i,
    input  logic [1:0]  ID_rd_src_i,
    input  logic [2:0]  ID_mem_op_size_i,
    input  logic        ID_mem_wr_en_i,
    input  logic        ID_Ld_sgn_i,
    input  logic [4:0]  FWD_wb_rd_i,
    input  logic        FWD_wb_wr_en_i,
    input  logic [31:0] FWD_wb_data_i,
    output logic [31:0] EX_ALU_result_o,
    output logic [31:0] EX_rs2_o,
    output logic [4:0]  EX_rd_o,
    output logic        EX_rd_wr_en_o,
    output logic [1:0]  EX_rd_src_o,
    output logic [2:0]  EX_mem_op_size_o,
    output logic        EX_mem_wr_en_o,
    output logic        EX_Ld_sgn_o,
    output logic        EX_redirect_o,
    output logic [31:0] EX_redirect_pc_o,
    output logic        EX_busy_o
);

    logic [31:0] rs1_fwd, rs2_fwd, op_a, op_b, alu_result, pc_plus4;
    logic        jump_any, br_taken, busy;

    logic [31:0] result_next, rs2_next;
    logic [4:0]  rd_next;
    logic        rd_wr_en_next, mem_wr_en_next, ld_sgn_next;
    logic [1:0]  rd_src_next;
    logic [2:0]  mem_op_size_next;

    assign rs1_fwd = fwd_operand(ID_rs1_i, ID_rs1_data_i, EX_rd_o, EX_rd_wr_en_o, EX_rd_src_o,
                                 EX_ALU_result_o, FWD_wb_rd_i, FWD_wb_wr_en_i, FWD_wb_data_i);
    assign rs2_fwd = fwd_operand(ID_rs2_i, ID_rs2_data_i, EX_rd_o, EX_rd_wr_en_o, EX_rd_src_o,
                                 EX_ALU_result_o, FWD_wb_rd_i, FWD_wb_wr_en_i, FWD_wb_data_i);

    assign op_a     = ID_alu_src_a_i ? ID_pc_i : rs1_fwd;
    assign op_b     = ID_alu_src_b_i ? ID_imm_i : rs2_fwd;
    assign pc_plus4 = ID_pc_i + 32'd4;
    assign jump_any = ID_jump_i | ID_jalr_i;

    ex_alu u_alu (
        .op_a   (op_a),
        .op_b   (op_b),
        .alu_op (ID_alu_op_i),
        .result (alu_result)
    );

    always_comb begin
        br_taken = 1'b0;
        case (ID_br_funct3_i)
            BR_EQ:   br_taken = (rs1_fwd == rs2_fwd);
            BR_NE:   br_taken = (rs1_fwd != rs2_fwd);
            BR_LT:   br_taken = ($signed(rs1_fwd) < $signed(rs2_fwd));
            BR_GE:   br_taken = ($signed(rs1_fwd) >= $signed(rs2_fwd));
            BR_LTU:  br_taken = (rs1_fwd < rs2_fwd);
            BR_GEU:  br_taken = (rs1_fwd >= rs2_fwd);
            default: br_taken = 1'b0;
        endcase
    end

    assign EX_redirect_o    = rst_ni & ID_valid_i & (jump_any | (ID_branch_i & br_taken));
    assign EX_redirect_pc_o = ID_jalr_i ? ((rs1_fwd + ID_imm_i) & ~32'd1) : (ID_pc_i + ID_imm_i);
    assign EX_busy_o        = rst_ni & busy;

`ifdef EX_SERIAL_SHIFT_EN
    ex_state_e   state_reg, state_next;
    logic [4:0]  count_reg, count_next;
    logic [31:0] shift_val_reg, shift_val_next, shift_step;
    logic        is_shift, capture;

    // Controls of the shift in flight, written back when the last bit is applied
    logic [3:0]  cap_op_reg;
    logic [4:0]  cap_rd_reg;
    logic        cap_rd_wr_en_reg, cap_mem_wr_en_reg, cap_ld_sgn_reg;
    logic [1:0]  cap_rd_src_reg;
    logic [2:0]  cap_mem_op_size_reg;
    logic [31:0] cap_rs2_reg;

    assign is_shift   = (ID_alu_op_i == ALU_SLL) || (ID_alu_op_i == ALU_SRL) ||
                        (ID_alu_op_i == ALU_SRA);
    assign shift_step = shift_one(shift_val_reg, cap_op_reg);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_reg           <= IDLE;
            count_reg           <= '0;
            shift_val_reg       <= '0;
            cap_op_reg          <= '0;
            cap_rd_reg          <= '0;
            cap_rd_wr_en_reg    <= 1'b0;
            cap_mem_wr_en_reg   <= 1'b0;
            cap_ld_sgn_reg      <= 1'b0;
            cap_rd_src_reg      <= '0;
            cap_mem_op_size_reg <= '0;
            cap_rs2_reg         <= '0;
        end else begin
            state_reg     <= state_next;
            count_reg     <= count_next;
            shift_val_reg <= shift_val_next;
            if (capture) begin
                cap_op_reg          <= ID_alu_op_i;
                cap_rd_reg          <= ID_rd_i;
                cap_rd_wr_en_reg    <= ID_rd_wr_en_i;
                cap_mem_wr_en_reg   <= ID_mem_wr_en_i;
                cap_ld_sgn_reg      <= ID_Ld_sgn_i;
                cap_rd_src_reg      <= ID_rd_src_i;
                cap_mem_op_size_reg <= ID_mem_op_size_i;
                cap_rs2_reg         <= rs2_fwd;
            end
        end
    end
`endif

    always_comb begin
        result_next      = jump_any ? pc_plus4 : alu_result;
        rs2_next         = rs2_fwd;
        rd_next          = ID_rd_i;
        rd_wr_en_next    = ID_valid_i & ID_rd_wr_en_i;
        rd_src_next      = ID_rd_src_i;
        mem_op_size_next = ID_mem_op_size_i;
        mem_wr_en_next   = ID_valid_i & ID_mem_wr_en_i;
        ld_sgn_next      = ID_Ld_sgn_i;
        busy             = 1'b0;
`ifdef EX_SERIAL_SHIFT_EN
        state_next     = state_reg;
        count_next     = count_reg;
        shift_val_next = shift_val_reg;
        capture        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (ID_valid_i && is_shift && (op_b[4:0] != 5'd0)) begin
                    state_next     = SHIFT;
                    count_next     = op_b[4:0];
                    shift_val_next = op_a;
                    capture        = 1'b1;
                    busy           = 1'b1;
                    rd_wr_en_next  = 1'b0;
                    mem_wr_en_next = 1'b0;
                end
            end
            SHIFT: begin
                shift_val_next = shift_step;
                count_next     = count_reg - 5'd1;
                if (count_reg == 5'd1) begin
                    state_next       = IDLE;
                    result_next      = shift_step;
                    rs2_next         = cap_rs2_reg;
                    rd_next          = cap_rd_reg;
                    rd_wr_en_next    = cap_rd_wr_en_reg;
                    rd_src_next      = cap_rd_src_reg;
                    mem_op_size_next = cap_mem_op_size_reg;
                    mem_wr_en_next   = cap_mem_wr_en_reg;
                    ld_sgn_next      = cap_ld_sgn_reg;
                end else begin
                    busy           = 1'b1;
                    rd_wr_en_next  = 1'b0;
                    mem_wr_en_next = 1'b0;
                end
            end
            default: state_next = IDLE;
        endcase
`endif
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            EX_ALU_result_o  <= '0;
            EX_rs2_o         <= '0;
            EX_rd_o          <= '0;
            EX_rd_wr_en_o    <= 1'b0;
            EX_rd_src_o      <= '0;
            EX_mem_op_size_o <= '0;
            EX_mem_wr_en_o   <= 1'b0;
            EX_Ld_sgn_o      <= 1'b0;
        end else begin
            EX_ALU_result_o  <= result_next;
            EX_rs2_o         <= rs2_next;
            EX_rd_o          <= rd_next;
            EX_rd_wr_en_o    <= rd_wr_en_next;
            EX_rd_src_o      <= rd_src_next;
            EX_mem_op_size_o <= mem_op_size_next;
            EX_mem_wr_en_o   <= mem_wr_en_next;
            EX_Ld_sgn_o      <= ld_sgn_next;
        end
    end

endmodule
